// File: rtl/pov_texture_mapper.sv
// Polar-to-texture mapper: turns (theta, LED index) into a multi-texture ROM address,
// scales the returned colour by global brightness and swaps textures only at revolution wrap.
module pov_texture_mapper #(
    parameter int LED_COUNT   = 52,
    parameter int TEX_WIDTH   = 256,
    parameter int THETA_BITS  = 6,
    parameter int PX_BITS     = 6,
    parameter int NUM_TEX     = 4,
    parameter int ROM_LATENCY = 1,
    parameter int COLOR_W     = 24
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [THETA_BITS-1:0]                         theta,
    input  logic [PX_BITS-1:0]                            px_num,
    input  logic [$clog2(NUM_TEX)-1:0]                    tex_req,
    input  logic                                          tex_req_valid,
    input  logic [7:0]                                    brightness,
    output logic [$clog2(NUM_TEX*TEX_WIDTH*LED_COUNT)-1:0] rom_addr,
    input  logic [COLOR_W-1:0]                            rom_data,
    output logic [COLOR_W-1:0]                            pixel,
    output logic [$clog2(NUM_TEX)-1:0]                    tex_active,
    output logic                                          tex_pending,
    output logic                                          frame_start
);
    localparam int TEX_BITS = $clog2(NUM_TEX);
    localparam int ADDR_W   = $clog2(NUM_TEX*TEX_WIDTH*LED_COUNT);
    localparam int COL_W    = $clog2(TEX_WIDTH);
    localparam int PROD_W   = THETA_BITS + COL_W + 1;
    localparam int NUM_CH   = COLOR_W / 8;
    localparam logic [PX_BITS:0] LED_LIMIT = (PX_BITS+1)'(LED_COUNT);

    typedef enum logic {ST_ACTIVE, ST_PENDING} state_t;

    state_t                  state;
    logic [TEX_BITS-1:0]     pend_tex;
    logic [THETA_BITS-1:0]   theta_prev;
    logic                    prev_valid;
    logic                    wrap;
    logic                    commit;
    logic [TEX_BITS-1:0]     tex_eff;
    logic [PROD_W-1:0]       col_prod;
    logic [COL_W-1:0]        col;
    logic [ADDR_W-1:0]       addr_next;
    logic                    in_range;
    logic [ROM_LATENCY:0]    valid_pipe;
    logic [ROM_LATENCY:0]    blank_pipe;
    logic [COLOR_W-1:0]      scaled;

    // Full-width product so coarse textures still spread evenly over the angle range
    assign col_prod  = PROD_W'(theta) * PROD_W'(TEX_WIDTH);
    assign col       = COL_W'(col_prod >> THETA_BITS);
    assign addr_next = ADDR_W'(tex_active) * ADDR_W'(TEX_WIDTH*LED_COUNT)
                     + ADDR_W'(px_num) * ADDR_W'(TEX_WIDTH)
                     + ADDR_W'(col);
    assign in_range  = {1'b0, px_num} < LED_LIMIT;

    assign wrap    = prev_valid && (theta < theta_prev);
    assign commit  = (state == ST_PENDING) && wrap;
    // A request arriving on the wrap cycle is judged against the texture being committed
    assign tex_eff = commit ? pend_tex : tex_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_ACTIVE;
            pend_tex    <= '0;
            tex_active  <= '0;
            tex_pending <= 1'b0;
            frame_start <= 1'b0;
            theta_prev  <= '0;
            prev_valid  <= 1'b0;
        end else begin
            theta_prev  <= theta;
            prev_valid  <= 1'b1;
            frame_start <= wrap;
            tex_active  <= tex_eff;
            if (tex_req_valid && (tex_req != tex_eff)) begin
                state       <= ST_PENDING;
                pend_tex    <= tex_req;
                tex_pending <= 1'b1;
            end else if (tex_req_valid || commit) begin
                state       <= ST_ACTIVE;
                tex_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr   <= '0;
            valid_pipe <= '0;
            blank_pipe <= '0;
        end else begin
            if (in_range) begin
                rom_addr <= addr_next;
            end
            valid_pipe <= {valid_pipe[ROM_LATENCY-1:0], 1'b1};
            blank_pipe <= {blank_pipe[ROM_LATENCY-1:0], !in_range};
        end
    end

    // (c * (b+1)) >> 8 keeps full brightness an exact identity
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_scale
            logic [15:0] prod;
            assign prod = {8'd0, rom_data[gi*8 +: 8]} * {7'd0, ({1'b0, brightness} + 9'd1)};
            assign scaled[gi*8 +: 8] = 8'(prod >> 8);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel <= '0;
        end else begin
            pixel <= (valid_pipe[ROM_LATENCY] && !blank_pipe[ROM_LATENCY]) ? scaled : '0;
        end
    end

endmodule

// File: tb/tb_pov_texture_mapper.sv
// Bench for pov_texture_mapper: directed literal checks plus a randomized run checked
// every cycle against a cycle-indexed behavioural model.
module tb_pov_texture_mapper;
    localparam int LED_COUNT  = 52;
    localparam int TEX_WIDTH  = 256;
    localparam int THETA_BITS = 6;
    localparam int PX_BITS    = 6;
    localparam int NUM_TEX    = 4;
    localparam int L          = 1;
    localparam int COLOR_W    = 24;
    localparam int ADDR_W     = $clog2(NUM_TEX*TEX_WIDTH*LED_COUNT);
    localparam int TEX_BITS   = $clog2(NUM_TEX);

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [THETA_BITS-1:0] theta = '0;
    logic [PX_BITS-1:0]    px_num = '0;
    logic [TEX_BITS-1:0]   tex_req = '0;
    logic                  tex_req_valid = 1'b0;
    logic [7:0]            brightness = 8'd255;
    logic [ADDR_W-1:0]     rom_addr;
    logic [COLOR_W-1:0]    rom_data;
    logic [COLOR_W-1:0]    pixel;
    logic [TEX_BITS-1:0]   tex_active;
    logic                  tex_pending;
    logic                  frame_start;

    int checks = 0;
    int failures = 0;

    pov_texture_mapper #(
        .LED_COUNT(LED_COUNT), .TEX_WIDTH(TEX_WIDTH), .THETA_BITS(THETA_BITS),
        .PX_BITS(PX_BITS), .NUM_TEX(NUM_TEX), .ROM_LATENCY(L), .COLOR_W(COLOR_W)
    ) dut (
        .clk(clk), .reset(reset), .theta(theta), .px_num(px_num),
        .tex_req(tex_req), .tex_req_valid(tex_req_valid), .brightness(brightness),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel),
        .tex_active(tex_active), .tex_pending(tex_pending), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // External ROM: either a fixed colour or an address hash
    int            rom_mode = 1;
    logic [23:0]   rom_const = 24'hFFFFFF;
    logic [23:0]   rom_pipe [L];
    assign rom_data = rom_pipe[L-1];

    function automatic logic [23:0] rom_func(int a);
        logic [31:0] h;
        if (rom_mode == 1) return rom_const;
        h = 32'(a) * 32'h9E3779B1;
        h = h ^ (h >> 13);
        return h[23:0];
    endfunction

    always @(posedge clk) begin
        rom_pipe[0] <= rom_func(int'(rom_addr));
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end

    function automatic logic [23:0] scale(logic [23:0] c, int b);
        logic [23:0] r;
        for (int i = 0; i < 3; i++) r[i*8 +: 8] = 8'((int'(c[i*8 +: 8]) * (b + 1)) / 256);
        return r;
    endfunction

    // Behavioural model, indexed by clock edges since reset release
    int          k = 0;
    int          m_addr = 0;
    int          m_tex = 0;
    bit          m_pend = 0;
    int          m_ptex = 0;
    int          m_prev = 0;
    bit          m_have = 0;
    bit          m_frame = 0;
    bit          hist_blank [8192];
    logic [23:0] exp_rom [8192];
    logic [23:0] exp_pix = '0;

    always @(posedge clk) begin : model
        int col;
        bit wrap;
        if (!reset) begin
            k = 0; m_addr = 0; m_tex = 0; m_pend = 0; m_ptex = 0;
            m_have = 0; m_frame = 0; exp_pix = '0;
        end else begin
            k++;
            exp_rom[k] = rom_func(m_addr);
            col = (int'(theta) * TEX_WIDTH) / (1 << THETA_BITS);
            hist_blank[k] = (int'(px_num) >= LED_COUNT);
            if (!hist_blank[k]) m_addr = m_tex*TEX_WIDTH*LED_COUNT + int'(px_num)*TEX_WIDTH + col;
            wrap = m_have && (int'(theta) < m_prev);
            m_frame = wrap;
            m_prev = int'(theta);
            m_have = 1;
            if (m_pend && wrap) begin
                m_tex = m_ptex;
                m_pend = 0;
            end
            if (tex_req_valid) begin
                if (int'(tex_req) != m_tex) begin
                    m_ptex = int'(tex_req);
                    m_pend = 1;
                end else begin
                    m_pend = 0;
                end
            end
            if (k - 1 - L >= 1)
                exp_pix = hist_blank[k-1-L] ? 24'h0 : scale(exp_rom[k-L], int'(brightness));
            else
                exp_pix = '0;
        end
    end

    task automatic cmp(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp("rst_rom_addr", rom_addr, 0);
            cmp("rst_pixel", pixel, 0);
            cmp("rst_tex_active", tex_active, 0);
            cmp("rst_tex_pending", tex_pending, 0);
            cmp("rst_frame_start", frame_start, 0);
        end else begin
            cmp("rom_addr", rom_addr, m_addr);
            cmp("pixel", pixel, exp_pix);
            cmp("tex_active", tex_active, m_tex);
            cmp("tex_pending", tex_pending, m_pend);
            cmp("frame_start", frame_start, m_frame);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b0;
        tick(3);
        cmp("pix_in_reset", pixel, 0);
        reset = 1'b1;
        tick(2);
        cmp("pix_lat2", pixel, 0);
        tick(1);
        cmp("pix_lat3", pixel, 24'hFFFFFF);

        theta = 6'd32; px_num = 6'd5;
        tick(1);
        cmp("addr_t32_px5", rom_addr, 1408);
        theta = 6'd63;
        tick(1);
        cmp("addr_t63_px5", rom_addr, 1532);

        theta = 6'd10; tex_req = 2'd2; tex_req_valid = 1'b1;
        tick(1);
        tex_req_valid = 1'b0;
        cmp("req2_pending", tex_pending, 1);
        cmp("req2_active_hold", tex_active, 0);
        theta = 6'd63; tick(1);
        theta = 6'd0;  tick(1);
        cmp("wrap_frame_start", frame_start, 1);
        cmp("wrap_active2", tex_active, 2);
        cmp("wrap_pending_clr", tex_pending, 0);
        cmp("wrap_addr_old_tex", rom_addr, 1280);
        tick(1);
        cmp("addr_tex2", rom_addr, 27904);
        cmp("frame_start_one", frame_start, 0);

        theta = 6'd5; tex_req = 2'd1; tex_req_valid = 1'b1; tick(1);
        tex_req = 2'd3; tick(1);
        tex_req_valid = 1'b0;
        cmp("last_req_pending", tex_pending, 1);
        theta = 6'd63; tick(1);
        theta = 6'd0;  tick(1);
        cmp("last_req_wins", tex_active, 3);
        tex_req = 2'd3; tex_req_valid = 1'b1; tick(1);
        tex_req_valid = 1'b0;
        cmp("same_req_ignored", tex_pending, 0);

        theta = 6'd20; tex_req = 2'd0; tex_req_valid = 1'b1; tick(1);
        tex_req_valid = 1'b0;
        theta = 6'd63; tick(1);
        theta = 6'd1;  tick(1);
        cmp("back_to_tex0", tex_active, 0);
        tex_req = 2'd2; tex_req_valid = 1'b1; tick(1);
        tex_req = 2'd0; tick(1);
        tex_req_valid = 1'b0;
        cmp("cancel_pending", tex_pending, 0);
        theta = 6'd63; tick(1);
        theta = 6'd0;  tick(1);
        cmp("cancel_wrap_pulse", frame_start, 1);
        cmp("cancel_no_switch", tex_active, 0);

        theta = 6'd32; rom_const = 24'hABCDEF; px_num = 6'd52;
        tick(3);
        cmp("blank_px52", pixel, 0);
        cmp("blank_addr_hold", rom_addr, 1280);
        px_num = 6'd51;
        tick(3);
        cmp("pass_px51", pixel, 24'hABCDEF);
        cmp("addr_px51", rom_addr, 13184);

        rom_const = 24'h80FF40; brightness = 8'd127;
        tick(3);
        cmp("bright127", pixel, 24'h407F20);
        brightness = 8'd0;
        tick(1);
        cmp("bright0", pixel, 0);

        rom_mode = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) theta = 6'($urandom_range(0, 63));
            else theta = 6'(theta + 1);
            px_num = 6'($urandom_range(0, 63));
            tex_req = 2'($urandom_range(0, 3));
            tex_req_valid = ($urandom_range(0, 5) == 0);
            brightness = 8'($urandom_range(0, 255));
            tick(1);
        end

        tex_req = 2'(m_tex + 1); tex_req_valid = 1'b1;
        tick(1);
        tex_req_valid = 1'b0;
        cmp("pending_before_rst", tex_pending, 1);
        #3 reset = 1'b0;
        #1;
        cmp("async_rst_pending", tex_pending, 0);
        cmp("async_rst_active", tex_active, 0);
        cmp("async_rst_pixel", pixel, 0);
        tick(2);
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            theta = 6'(theta + 1);
            px_num = 6'($urandom_range(0, 63));
            tex_req = 2'($urandom_range(0, 3));
            tex_req_valid = ($urandom_range(0, 7) == 0);
            brightness = 8'($urandom_range(0, 255));
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pov_texture_mapper.md
Name: pov_texture_mapper

Overview:
- Parametrised polar-to-texture mapper between the breakbeam angle generator and the neopixel strip controller.
- Converts (theta, LED index) into a multi-texture ROM address and registers the returned colour.
- Applies global brightness scaling and blanks out-of-range LEDs.
- Switches textures only at revolution wrap, so a frame never mixes two textures.

Parameters:
- LED_COUNT, 52, number of LEDs on the arm (texture rows).
- TEX_WIDTH, 256, texture columns per revolution; power of two.
- THETA_BITS, 6, width of the angle index.
- PX_BITS, 6, width of the LED index from the strip controller.
- NUM_TEX, 4, textures stored back-to-back in one ROM; power of two ≥2.
- ROM_LATENCY, 1, read latency of the external ROM in clocks (≥1).
- COLOR_W, 24, pixel width: three 8-bit channels, G[23:16] R[15:8] B[7:0].

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- theta, input, THETA_BITS, current angle index.
- px_num, input, PX_BITS, LED index requested by the strip controller.
- tex_req, input, $clog2(NUM_TEX), requested texture.
- tex_req_valid, input, 1, one-cycle strobe qualifying tex_req.
- brightness, input, 8, global brightness; 255 = full.
- rom_addr, output, $clog2(NUM_TEX*TEX_WIDTH*LED_COUNT), registered ROM address.
- rom_data, input, COLOR_W, ROM read data, ROM_LATENCY clocks after rom_addr.
- pixel, output, COLOR_W, scaled colour for the strip controller.
- tex_active, output, $clog2(NUM_TEX), texture currently displayed.
- tex_pending, output, 1, a switch request is waiting for wrap.
- frame_start, output, 1, one-cycle pulse on revolution wrap.

Behaviour:
- Reset (async assert, sync release): rom_addr=0, pixel=0, tex_active=0, tex_pending=0, frame_start=0, all pipeline valid/blank flags cleared.
- Column: col = (theta*TEX_WIDTH) >> THETA_BITS.
  - Full-width product; no truncation before the shift.
  - When TEX_WIDTH < 2^THETA_BITS, several theta values map to one column.
- Address, registered at stage 1: rom_addr = tex_active*TEX_WIDTH*LED_COUNT + px_num*TEX_WIDTH + col.
- Out-of-range LED (px_num ≥ LED_COUNT):
  - rom_addr holds its previous value.
  - A blank flag travels down the pipe and forces pixel=0 at output.
- Wrap detect:
  - theta_prev is registered.
  - Wrap when theta < theta_prev (covers max→0 and any backward jump).
  - frame_start pulses exactly one cycle per wrap.
  - First cycle after reset never counts as a wrap; theta_prev initialises from theta.
- Texture FSM, two states:
  - ACTIVE:
    - tex_req_valid with tex_req≠tex_active → latch pend_tex, go PENDING, tex_pending=1.
    - tex_req_valid with tex_req==tex_active → ignored.
  - PENDING:
    - On wrap: tex_active←pend_tex, tex_pending←0, return to ACTIVE.
    - New tex_req_valid before wrap overwrites pend_tex (last request wins).
    - A request equal to tex_active cancels the pending switch → ACTIVE.
  - Request and wrap in the same cycle:
    - Wrap commits the older pend_tex.
    - The new request is then evaluated against the updated tex_active.
  - tex_req ≥ NUM_TEX (only possible when NUM_TEX is not a power of two; disallowed by parameter rule) — no check required.
  - The new tex_active affects rom_addr from the cycle after the wrap cycle.
- Data path:
  - rom_data arrives ROM_LATENCY clocks after rom_addr.
  - One scaling register follows: channel_out = (channel_in*(brightness+1)) >> 8.
  - brightness=255 is identity; brightness=0 gives ≤ in/256, i.e. 0 for 8-bit inputs.
  - brightness is sampled at the scaling stage.
- Total latency, px_num/theta to pixel: 2+ROM_LATENCY clocks.
  - The pipeline is free-running, with no stalls.
  - The strip controller requests its next pixel well ahead of use.
- Reset mid-frame: pending request discarded, tex_active=0, pipeline flushed to 0.

Test Plan:
- Reset, theta=0, px_num=0, ROM returns 0xFFFFFF, brightness=255 → pixel=0x000000 while reset low; pixel=0xFFFFFF at clock 3 after release (ROM_LATENCY=1).
- theta=32, px_num=5, tex_active=0, defaults → rom_addr=5*256+128=1408 one clock later; theta=63 → col=252.
- tex_req=2 strobed at theta=10 → tex_pending=1, tex_active stays 0; theta 63→0 → frame_start pulse, tex_active=2, next rom_addr offset +2*13312=26624.
- Requests 1 then 3 before wrap → tex_active=3 after wrap; then request 3 again → no pending set. Separately, with tex_active=0: request 2, then request 0 before wrap → pending cancelled, no switch at wrap.
- px_num=52 with rom_data=0xABCDEF → pixel=0 at latency 3; px_num=51 → ROM value passes.
- rom_data=0x80FF40, brightness=127 → pixel=0x407F20; brightness=0 → 0x000000; async reset asserted mid-PENDING → tex_pending=0, tex_active=0 immediately.
